// File: rtl/riscv_defines.sv
// Shared RISC-V execute-stage types: ALU operation codes and divider state encoding.
package riscv_defines;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] XLEN_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alucontrol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divstate_t;

  function automatic logic is_div_op(input alucontrol_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a start/busy/done handshake.
// Divide-by-zero and signed overflow are resolved at acceptance and skip the iteration.
module alu_div_unit
  import riscv_defines::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  alucontrol_t       alucontrol,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  divstate_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op_s, rem_op_s, a_neg_s, b_neg_s;
  logic             div0_s, ovf_s;
  logic [XLEN-1:0]  special_s;
  logic [XLEN:0]    trial_s;
  logic [XLEN-1:0]  step_rem_s, step_quo_s, final_s;

  // Operand decode and special-case result, evaluated for a request in IDLE.
  always_comb begin
    signed_op_s = (alucontrol == ALU_DIV) || (alucontrol == ALU_REM);
    rem_op_s    = (alucontrol == ALU_REM) || (alucontrol == ALU_REMU);
    a_neg_s     = signed_op_s & src_a[XLEN-1];
    b_neg_s     = signed_op_s & src_b[XLEN-1];
    div0_s      = (src_b == XLEN_ZERO);
    ovf_s       = signed_op_s && (src_a == XLEN_MIN) && (src_b == XLEN_ONES);
    if (div0_s) begin
      special_s = rem_op_s ? src_a : XLEN_ONES;
    end else begin
      special_s = rem_op_s ? XLEN_ZERO : src_a;
    end
  end

  // One restoring step: the (XLEN+1)-bit trial difference's MSB is the borrow.
  always_comb begin
    trial_s = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (!trial_s[XLEN]) begin
      step_rem_s = trial_s[XLEN-1:0];
      step_quo_s = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      step_rem_s = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      step_quo_s = {quo_q[XLEN-2:0], 1'b0};
    end
    if (is_rem_q) begin
      final_s = negate_if(step_rem_s, neg_rem_q);
    end else begin
      final_s = negate_if(step_quo_s, neg_quo_q);
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && is_div_op(alucontrol)) begin
            is_rem_d  = rem_op_s;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            rem_d     = XLEN_ZERO;
            quo_d     = negate_if(src_a, a_neg_s);
            dvs_d     = negate_if(src_b, b_neg_s);
            cnt_d     = CNT_ZERO;
            if (div0_s || ovf_s) begin
              result_d = special_s;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            result_d = final_s;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      rem_q     <= XLEN_ZERO;
      quo_q     <= XLEN_ZERO;
      dvs_q     <= XLEN_ZERO;
      result_q  <= XLEN_ZERO;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
